// File: rtl/pipeline_stall_controller_if.sv
`default_nettype none
// ============================================================================
// pipeline_stall_controller_if : event inputs and pipeline controls
// Rev 1.0
// ============================================================================
interface pipeline_stall_controller_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             load_use_stall;
    logic             branch_taken;
    logic [XLEN-1:0]  branch_target;
    logic             icache_stall;
    logic             dcache_stall;

    logic             pc_write;
    logic             pc_sel;
    logic [XLEN-1:0]  pc_redirect;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_write;
    logic             idex_flush;
    logic             exmem_write;
    logic             memwb_write;
    logic             memwb_flush;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        input  load_use_stall, branch_taken, branch_target, icache_stall, dcache_stall,
        output pc_write, pc_sel, pc_redirect, ifid_write, ifid_flush, idex_write,
               idex_flush, exmem_write, memwb_write, memwb_flush,
               stall_cycles, flush_events
    );

    modport slave (
        output load_use_stall, branch_taken, branch_target, icache_stall, dcache_stall,
        input  pc_write, pc_sel, pc_redirect, ifid_write, ifid_flush, idex_write,
               idex_flush, exmem_write, memwb_write, memwb_flush,
               stall_cycles, flush_events
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
// pipeline_stall_controller : merges hazard/branch/cache events into PC and
// pipeline-register controls, with stall and flush counters.
// Rev 1.0
// ============================================================================
module pipeline_stall_controller #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    pipeline_stall_controller_if.master bus
);
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [XLEN-1:0]  redir_q, redir_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_events_q, flush_events_d;

    logic w_pc_write, w_pc_sel, w_ifid_write, w_ifid_flush, w_idex_write;
    logic w_idex_flush, w_exmem_write, w_memwb_write, w_memwb_flush;

    always_comb begin
        w_pc_write     = 1'b1;
        w_pc_sel       = 1'b0;
        w_ifid_write   = 1'b1;
        w_ifid_flush   = 1'b0;
        w_idex_write   = 1'b1;
        w_idex_flush   = 1'b0;
        w_exmem_write  = 1'b1;
        w_memwb_write  = 1'b1;
        w_memwb_flush  = 1'b0;
        state_d        = state_q;
        redir_d        = redir_q;
        flush_events_d = flush_events_q;

        if (rst) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_write  = 1'b0;
            w_exmem_write = 1'b0;
            w_memwb_write = 1'b0;
            w_ifid_flush  = 1'b1;
            w_idex_flush  = 1'b1;
            w_memwb_flush = 1'b1;
        end else if (bus.dcache_stall) begin
            // EX is frozen too, so a taken branch is re-presented next cycle
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_write  = 1'b0;
            w_exmem_write = 1'b0;
            w_memwb_flush = 1'b1;
        end else if (state_q == RUN && bus.branch_taken) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
            if (bus.icache_stall) begin
                w_pc_write = 1'b0;
                redir_d    = bus.branch_target;
                state_d    = PEND;
            end else begin
                w_pc_sel       = 1'b1;
                flush_events_d = flush_events_q + C_CNT_ONE;
            end
        end else if (state_q == PEND) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
            if (bus.icache_stall) begin
                w_pc_write = 1'b0;
            end else begin
                w_pc_sel       = 1'b1;
                flush_events_d = flush_events_q + C_CNT_ONE;
                state_d        = RUN;
            end
        end else if (bus.icache_stall) begin
            w_pc_write = 1'b0;
            if (bus.load_use_stall) begin
                w_ifid_write = 1'b0;
                w_idex_flush = 1'b1;
            end else begin
                w_ifid_flush = 1'b1;
            end
        end else if (bus.load_use_stall) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_idex_flush = 1'b1;
        end

        stall_cycles_d = stall_cycles_q;
        if (!rst && !w_pc_write) begin
            stall_cycles_d = stall_cycles_q + C_CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= RUN;
            redir_q        <= '0;
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            state_q        <= state_d;
            redir_q        <= redir_d;
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign bus.pc_write     = w_pc_write;
    assign bus.pc_sel       = w_pc_sel;
    assign bus.pc_redirect  = (state_q == PEND) ? redir_q : bus.branch_target;
    assign bus.ifid_write   = w_ifid_write;
    assign bus.ifid_flush   = w_ifid_flush;
    assign bus.idex_write   = w_idex_write;
    assign bus.idex_flush   = w_idex_flush;
    assign bus.exmem_write  = w_exmem_write;
    assign bus.memwb_write  = w_memwb_write;
    assign bus.memwb_flush  = w_memwb_flush;
    assign bus.stall_cycles = stall_cycles_q;
    assign bus.flush_events = flush_events_q;
endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
// tb_pipeline_stall_controller : random + directed stimulus vs behavioural model
// Rev 1.0
// ============================================================================
module tb_pipeline_stall_controller;
    localparam int XLEN  = 32;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipeline_stall_controller_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    pipeline_stall_controller #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model state: is a redirect owed to fetch, and where to.
    bit          m_pending;
    logic [31:0] m_target;
    logic [31:0] m_stalls;
    logic [31:0] m_flushes;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pending = 0;
        m_target  = '0;
        m_stalls  = '0;
        m_flushes = '0;
    endtask

    // A redirect is "due" whenever a branch is owed; it lands when fetch is free.
    task automatic model_compare();
        bit dc, ic, lu, due, lands;
        dc    = bus.dcache_stall;
        ic    = bus.icache_stall;
        lu    = bus.load_use_stall;
        due   = !dc && (m_pending || bus.branch_taken);
        lands = due && !ic;
        chk("pc_write",    bus.pc_write,    !dc && !ic && (due || !lu));
        chk("pc_sel",      bus.pc_sel,      lands);
        chk("ifid_write",  bus.ifid_write,  !dc && (due || !lu));
        chk("ifid_flush",  bus.ifid_flush,  !dc && (due || (ic && !lu)));
        chk("idex_write",  bus.idex_write,  !dc);
        chk("idex_flush",  bus.idex_flush,  !dc && (due || lu));
        chk("exmem_write", bus.exmem_write, !dc);
        chk("memwb_write", bus.memwb_write, 1'b1);
        chk("memwb_flush", bus.memwb_flush, dc);
        if (m_pending || bus.branch_taken)
            chk("pc_redirect", bus.pc_redirect, m_pending ? m_target : bus.branch_target);
        chk("stall_cycles", bus.stall_cycles, m_stalls);
        chk("flush_events", bus.flush_events, m_flushes);
    endtask

    task automatic model_advance();
        bit dc, ic, lu, due;
        dc  = bus.dcache_stall;
        ic  = bus.icache_stall;
        lu  = bus.load_use_stall;
        due = !dc && (m_pending || bus.branch_taken);
        if (dc || ic || (!due && lu)) m_stalls++;
        if (due && !ic) begin
            m_flushes++;
            m_pending = 0;
        end else if (due && !m_pending) begin
            m_pending = 1;
            m_target  = bus.branch_target;
        end
    endtask

    task automatic drive(input bit lu, input bit bt, input logic [31:0] tgt,
                         input bit ic, input bit dc);
        bus.load_use_stall = lu;
        bus.branch_taken   = bt;
        bus.branch_target  = tgt;
        bus.icache_stall   = ic;
        bus.dcache_stall   = dc;
        @(negedge clk);
        model_compare();
    endtask

    task automatic step();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_pc_write",    bus.pc_write,    1'b0);
        chk("rst_pc_sel",      bus.pc_sel,      1'b0);
        chk("rst_ifid_write",  bus.ifid_write,  1'b0);
        chk("rst_idex_write",  bus.idex_write,  1'b0);
        chk("rst_exmem_write", bus.exmem_write, 1'b0);
        chk("rst_memwb_write", bus.memwb_write, 1'b0);
        chk("rst_flushes",     {bus.ifid_flush, bus.idex_flush, bus.memwb_flush}, 3'b111);
        chk("rst_stall_cnt",   bus.stall_cycles, 32'd0);
        chk("rst_flush_cnt",   bus.flush_events, 32'd0);
    endtask

    // Assert reset away from the clock edge and release it away from the edge too.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1 check_reset_outputs();
        model_reset();
        @(posedge clk);
        #1 check_reset_outputs();
        #2 rst = 1'b0;
    endtask

    initial begin
        bus.load_use_stall = 0;
        bus.branch_taken   = 0;
        bus.branch_target  = '0;
        bus.icache_stall   = 0;
        bus.dcache_stall   = 0;
        model_reset();
        do_reset();

        // Load-use stall for one cycle
        drive(0, 0, 0, 0, 0); step();
        drive(1, 0, 0, 0, 0);
        chk("t1_pc_write", bus.pc_write, 1'b0);
        chk("t1_ifid_write", bus.ifid_write, 1'b0);
        chk("t1_idex_flush", bus.idex_flush, 1'b1);
        chk("t1_exmem_write", bus.exmem_write, 1'b1);
        step();
        drive(0, 0, 0, 0, 0);
        chk("t1_all_run", {bus.pc_write, bus.ifid_write, bus.idex_write, bus.ifid_flush, bus.idex_flush}, 5'b11100);
        chk("t1_stalls", bus.stall_cycles, 32'd1);
        step();

        // Branch beats load-use
        do_reset();
        drive(1, 1, 32'h100, 0, 0);
        chk("t2_pc_sel", bus.pc_sel, 1'b1);
        chk("t2_redirect", bus.pc_redirect, 32'h100);
        chk("t2_ifid", {bus.ifid_write, bus.ifid_flush, bus.idex_flush}, 3'b111);
        step();
        drive(0, 0, 0, 0, 0);
        chk("t2_flushes", bus.flush_events, 32'd1);
        chk("t2_stalls", bus.stall_cycles, 32'd0);
        step();

        // Branch held pending behind an icache miss
        do_reset();
        drive(0, 1, 32'h200, 1, 0); step();
        drive(0, 0, 0, 1, 0); step();
        drive(0, 0, 0, 1, 0);
        chk("t3_pend_redirect", bus.pc_redirect, 32'h200);
        step();
        drive(0, 0, 0, 0, 0);
        chk("t3_pc_sel", bus.pc_sel, 1'b1);
        chk("t3_redirect", bus.pc_redirect, 32'h200);
        step();
        drive(0, 0, 0, 0, 0);
        chk("t3_back_to_run", bus.pc_sel, 1'b0);
        chk("t3_flushes", bus.flush_events, 32'd1);
        chk("t3_stalls", bus.stall_cycles, 32'd3);
        step();

        // dcache freeze with branch held in EX
        do_reset();
        repeat (2) begin
            drive(0, 1, 32'h300, 0, 1);
            chk("t4_freeze", {bus.pc_write, bus.ifid_write, bus.idex_write, bus.exmem_write, bus.pc_sel}, 5'b00000);
            chk("t4_memwb_flush", bus.memwb_flush, 1'b1);
            step();
        end
        drive(0, 1, 32'h300, 0, 0);
        chk("t4_pc_sel", bus.pc_sel, 1'b1);
        step();
        drive(0, 0, 0, 0, 0);
        chk("t4_flushes", bus.flush_events, 32'd1);
        step();

        // dcache freeze while pending
        do_reset();
        drive(0, 1, 32'h400, 1, 0); step();
        drive(0, 0, 0, 1, 1); step();
        drive(0, 0, 0, 0, 1);
        chk("t5_hold_redirect", bus.pc_redirect, 32'h400);
        chk("t5_freeze_sel", bus.pc_sel, 1'b0);
        step();
        drive(0, 0, 0, 0, 0);
        chk("t5_pc_sel", bus.pc_sel, 1'b1);
        chk("t5_redirect", bus.pc_redirect, 32'h400);
        step();

        // Reset mid-PEND discards the pending redirect
        do_reset();
        drive(0, 1, 32'h500, 1, 0); step();
        drive(0, 0, 0, 1, 0);
        do_reset();
        drive(0, 0, 0, 0, 0);
        chk("t6_seq_sel", bus.pc_sel, 1'b0);
        chk("t6_seq_write", bus.pc_write, 1'b1);
        step();

        // Randomized traffic; EX cannot present a branch while a redirect is owed
        for (int i = 0; i < 3000; i++) begin
            bit lu, bt, ic, dc;
            logic [31:0] tgt;
            if ($urandom_range(0, 199) == 0) do_reset();
            lu  = ($urandom_range(0, 3) == 0);
            bt  = !m_pending && ($urandom_range(0, 3) == 0);
            ic  = ($urandom_range(0, 2) == 0);
            dc  = ($urandom_range(0, 4) == 0);
            tgt = $urandom;
            drive(lu, bt, tgt, ic, dc);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
